// File: rtl/uart_cmd_if.sv
// Memory access bus between the command parser (master) and the PSRAM test controller (slave).
interface uart_cmd_if #(
  parameter int ADDR_W = 24
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/uart_cmd.sv
// ASCII hex command parser: "R<addr>CR" / "W<addr><data>CR" from the uart become one memory
// access each, answered with "<hex>CRLF", "KCRLF" or "?CRLF" through the uart transmitter.
// state | meaning
// IDLE  | waiting for 'R'/'W'; CR/LF ignored
// ADDR  | collecting ND address hex digits, MS nibble first
// DATA  | collecting 2 write-data hex digits
// EOL   | waiting for the terminating CR
// MEM   | mem_req held until mem_ack
// RESP  | sending the reply string
module uart_cmd #(
  parameter int ADDR_W = 24
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [9:0] uart_rx_arr,
  output logic       uart_rx_read,
  output logic       uart_tx_write,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_busy,
  uart_cmd_if.master mem
);
  localparam int ND = ADDR_W / 4;
  localparam int CW = $clog2(ND + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_EOL, S_MEM, S_RESP} state_t;
  typedef enum logic [1:0] {RP_READ, RP_WRITE, RP_ERR} reply_t;

  state_t        state;
  reply_t        reply;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    rdata;

  logic [7:0] rx_byte;
  logic [4:0] hex;
  logic       is_r, is_w, is_crlf, parse_st, take, bad;
  logic [1:0] last_idx;

  // {valid, nibble}
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    else                               return 5'd0;
  endfunction

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  function automatic logic [7:0] reply_byte(input reply_t k, input logic [1:0] i,
                                            input logic [7:0] rd);
    if (k == RP_READ) begin
      case (i)
        2'd0:    return hex_enc(rd[7:4]);
        2'd1:    return hex_enc(rd[3:0]);
        2'd2:    return 8'h0D;
        default: return 8'h0A;
      endcase
    end
    case (i)
      2'd0:    return (k == RP_WRITE) ? 8'h4B : 8'h3F;
      2'd1:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign rx_byte  = uart_rx_arr[7:0];
  assign hex      = hex_dec(rx_byte);
  assign is_r     = (rx_byte == 8'h52) || (rx_byte == 8'h72);
  assign is_w     = (rx_byte == 8'h57) || (rx_byte == 8'h77);
  assign is_crlf  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign parse_st = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA) || (state == S_EOL);
  // uart_rx_read high means the pending byte was already consumed last cycle
  assign take     = uart_rx_arr[9] && !uart_rx_read && parse_st;
  assign last_idx = (reply == RP_READ) ? 2'd3 : 2'd2;

  always_comb begin
    bad = 1'b0;
    case (state)
      S_IDLE:         bad = !(is_r || is_w || is_crlf);
      S_ADDR, S_DATA: bad = !hex[4];
      S_EOL:          bad = (rx_byte != 8'h0D);
      default:        bad = 1'b0;
    endcase
    if (uart_rx_arr[8]) bad = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= S_IDLE;
      reply         <= RP_READ;
      idx           <= 2'd0;
      cnt           <= '0;
      rdata         <= 8'd0;
      uart_rx_read  <= 1'b0;
      uart_tx_write <= 1'b0;
      uart_tx_data  <= 8'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 8'd0;
    end else begin
      uart_rx_read  <= take;
      uart_tx_write <= 1'b0;
      if (take) begin
        if (bad) begin
          reply <= RP_ERR;
          idx   <= 2'd0;
          state <= S_RESP;
        end else begin
          case (state)
            S_IDLE: if (is_r || is_w) begin
              mem.mem_we <= is_w;
              cnt        <= '0;
              state      <= S_ADDR;
            end
            S_ADDR: begin
              mem.mem_addr <= (mem.mem_addr << 4) | ADDR_W'(hex[3:0]);
              if (cnt == CW'(ND - 1)) begin
                cnt   <= '0;
                state <= mem.mem_we ? S_DATA : S_EOL;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            S_DATA: begin
              mem.mem_wdata <= {mem.mem_wdata[3:0], hex[3:0]};
              if (cnt == CW'(1)) begin
                cnt   <= '0;
                state <= S_EOL;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            S_EOL: begin
              mem.mem_req <= 1'b1;
              state       <= S_MEM;
            end
            default: ;
          endcase
        end
      end else if (state == S_MEM) begin
        if (mem.mem_ack) begin
          mem.mem_req <= 1'b0;
          rdata       <= mem.mem_rdata;
          reply       <= mem.mem_we ? RP_WRITE : RP_READ;
          idx         <= 2'd0;
          state       <= S_RESP;
        end
      end else if (state == S_RESP) begin
        // busy only rises the cycle after a write, so never write back-to-back
        if (!uart_tx_busy && !uart_tx_write) begin
          uart_tx_write <= 1'b1;
          uart_tx_data  <= reply_byte(reply, idx, rdata);
          if (idx == last_idx) state <= S_IDLE;
          else                 idx   <= idx + 2'd1;
        end
      end
    end
  end
endmodule
